// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO replaying stores as setup/strobe/recover writes, with load forwarding; STORE_BUF_COALESCE_EN enables in-place merge into the youngest entry.
// One write per 3 cycles; forwarded load result one cycle after lookup; st_ready_o drops when DEPTH entries are held.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid_i,
   input  logic [31:0]      st_addr_i,
   input  logic [31:0]      st_data_i,
   output logic             st_ready_o,
   output logic             st_err_o,
   input  logic             ld_valid_i,
   input  logic [31:0]      ld_addr_i,
   output logic             ld_hit_o,
   output logic [31:0]      ld_data_o,
   output logic [31:0]      y_o,
   output logic [31:0]      pass_o,
   output logic             we_o,
   output logic [PTR_W:0]   count_o,
   output logic             idle_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETUP   = 2'd1;
   localparam logic [1:0] S_STROBE  = 2'd2;
   localparam logic [1:0] S_RECOVER = 2'd3;

   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

   logic [29:0]      addr_q [DEPTH];
   logic [29:0]      addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic             we_q, we_d;
   logic [31:0]      y_q, y_d, pass_q, pass_d;
   logic             err_q, err_d;
   logic             ld_hit_q, ld_hit_d;
   logic [31:0]      ld_data_q, ld_data_d;

   logic [PTR_W-1:0] young_idx, fwd_idx;
   logic             aligned, push, pop, coal, fwd_hit;
   logic [31:0]      fwd_data;
   logic             ld_lsb_unused;

   assign ld_lsb_unused = ^ld_addr_i[1:0];

   assign st_ready_o = (count_q < DEPTH_C);
   assign aligned    = (st_addr_i[1:0] == 2'b00);
   assign young_idx  = tail_q - ONE_P;
   assign pop        = (state_q == S_RECOVER);

`ifdef STORE_BUF_COALESCE_EN
   // The head is frozen once its write sequence has started, so it cannot absorb a merge.
   assign coal = st_valid_i && aligned && (count_q != '0) && vld_q[young_idx]
              && (addr_q[young_idx] == st_addr_i[31:2])
              && !((young_idx == head_q) && (state_q != S_IDLE));
`else
   assign coal = 1'b0;
`endif

   assign push  = st_valid_i && st_ready_o && aligned && !coal;
   assign err_d = st_valid_i && st_ready_o && !aligned;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      vld_d   = vld_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (coal) begin
         data_d[young_idx] = st_data_i;
      end
      if (push) begin
         addr_d[tail_q] = st_addr_i[31:2];
         data_d[tail_q] = st_data_i;
         vld_d[tail_q]  = 1'b1;
         tail_d         = tail_q + ONE_P;
      end
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + ONE_P;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE:   if (count_q != '0) state_d = S_SETUP;
         S_SETUP:  state_d = S_STROBE;
         S_STROBE: state_d = S_RECOVER;
         default:  state_d = (count_d != '0) ? S_SETUP : S_IDLE;
      endcase
      // Load the write port from post-update entry state so a same-cycle push or merge is seen.
      if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
         y_d    = {addr_d[head_d], 2'b00};
         pass_d = data_d[head_d];
      end
   end

   assign we_d = (state_d == S_STROBE);

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) && vld_q[fwd_idx] &&
             (addr_q[fwd_idx] == ld_addr_i[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end

   assign ld_hit_d  = ld_valid_i && fwd_hit;
   assign ld_data_d = ld_hit_d ? fwd_data : ld_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         vld_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         y_q       <= '0;
         pass_q    <= '0;
         err_q     <= 1'b0;
         ld_hit_q  <= 1'b0;
         ld_data_q <= '0;
      end else begin
         addr_q    <= addr_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         state_q   <= state_d;
         we_q      <= we_d;
         y_q       <= y_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         ld_hit_q  <= ld_hit_d;
         ld_data_q <= ld_data_d;
      end
   end

   assign st_err_o  = err_q;
   assign ld_hit_o  = ld_hit_q;
   assign ld_data_o = ld_data_q;
   assign y_o       = y_q;
   assign pass_o    = pass_q;
   assign we_o      = we_q;
   assign count_o   = count_q;
   assign idle_o    = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly upstream of the data-memory stage.
- Accepts word stores from execute and holds them in a small FIFO.
- Replays each store into the memory stage's edge-triggered write port as a clean setup/strobe/recover sequence on y, pass and we.
- Forwards buffered data to younger loads, so a load that follows an undrained store reads the new value.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2 to 16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- st_valid_i  input  1  store request
- st_addr_i  input  32  store byte address; must be word aligned
- st_data_i  input  32  store data
- st_ready_o  output  1  buffer can accept a store this cycle
- st_err_o  output  1  one-cycle pulse: misaligned store dropped
- ld_valid_i  input  1  load lookup request
- ld_addr_i  input  32  load byte address
- ld_hit_o  output  1  registered: previous-cycle load matched a buffered store
- ld_data_o  output  32  registered forwarded data, valid when ld_hit_o=1
- y_o  output  32  address to memory stage
- pass_o  output  32  write data to memory stage
- we_o  output  1  write strobe to memory stage; rising edge commits
- count_o  output  PTR_W+1  entries currently held, including the entry being drained
- idle_o  output  1  count_o==0 and drain FSM in IDLE

Behaviour:
- Reset (asynchronous, reset=0) forces these values immediately:
  - FIFO pointers and count_o to 0; all entry valid bits to 0.
  - Drain FSM to IDLE.
  - we_o, st_err_o, ld_hit_o to 0; y_o, pass_o, ld_data_o to 0.
  - st_ready_o=1 and idle_o=1.
- Reset mid-drain: we_o drops at once. Any store whose strobe edge had not yet occurred is lost.
- Push:
  - Occurs when st_valid_i && st_ready_o && st_addr_i[1:0]==0.
  - The entry is written at the tail in that cycle; count_o increments next cycle.
  - st_ready_o = (count_o < DEPTH), taken from registered count only; no same-cycle bypass of a pop.
- Misaligned store (st_valid_i && st_ready_o && st_addr_i[1:0]!=0): not enqueued; st_err_o pulses high the next cycle.
- Drain FSM, one memory write per 3 cycles:
  - IDLE -> SETUP when count_o>0.
  - SETUP: y_o/pass_o = head entry; we_o=0.
  - STROBE: we_o=1; y_o/pass_o held.
  - RECOVER: we_o=0; y_o/pass_o held; head pops at the end of the cycle.
  - RECOVER -> SETUP if an entry remains after the pop, else -> IDLE.
  - y_o/pass_o never change while we_o=1 or in the cycle before it rises.
- Simultaneous push and pop (RECOVER): count_o unchanged; both pointers advance.
- Pointer wrap: modulo DEPTH. count_o distinguishes full from empty.
- Load forwarding:
  - On ld_valid_i, compare ld_addr_i[31:2] against every valid entry, including the head being drained.
  - The youngest match wins.
  - ld_hit_o/ld_data_o are registered: they appear the cycle after ld_valid_i, aligned with the memory stage's registered read data.
  - A push in the same cycle as the lookup is not visible to that lookup.
  - ld_valid_i=0 gives ld_hit_o=0 next cycle; ld_data_o holds its last value.
- The memory stage sees only y_o, pass_o, we_o; it never sees a second edge per entry.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - A valid aligned store whose word address matches the youngest entry overwrites that entry's data in place.
  - No allocation and no count change; accepted even when full.
  - Does not apply if that entry is the head and the FSM is in SETUP, STROBE or RECOVER; a new entry is allocated instead.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then store 0x0000_0010 <- 0xDEAD_BEEF: exactly one we_o rising edge with y_o=0x10, pass_o=0xDEADBEEF stable one cycle before and after the edge; idle_o=1 after 4 cycles.
- Push 5 stores back-to-back with DEPTH=4: st_ready_o=0 after the 4th until the first RECOVER pops. Drain order is 0x100, 0x104, 0x108, 0x10C, 0x110, with 5 we_o pulses.
- Store 0x20 <- 0x1111, then 0x20 <- 0x2222 (COALESCE undefined), then load 0x22 before drain: ld_hit_o=1, ld_data_o=0x2222 next cycle.
- Store to 0x33: no enqueue, st_err_o high for one cycle, count_o stays 0, no we_o edge.
- Assert reset low during STROBE: we_o=0 in the same cycle, count_o=0, no further strobes after release.
- With STORE_BUF_COALESCE_EN, push 0x40 <- 1, 0x44 <- 2, 0x44 <- 3 while head draining 0x40: count_o peaks at 2; memory receives 0x40=1 and 0x44=3 only.
